// File: rtl/fp_product_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fp_product_arbiter_pkg
// Shared definitions for the two-requester floating-point product arbiter:
//   - default field widths of the {sign, expo, mant} word
//   - FSM state encoding
//   - exception class codes reported on o_rsp_exc
// ---------------------------------------------------------------------------
package fp_product_arbiter_pkg;

   localparam int NB_SIGN_DEF = 1;
   localparam int NB_EXPO_DEF = 4;
   localparam int NB_MANT_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } fsm_state_e;

   localparam logic [1:0] EXC_NORMAL = 2'b00;
   localparam logic [1:0] EXC_ZERO   = 2'b01;
   localparam logic [1:0] EXC_INF    = 2'b10;

endpackage

// File: rtl/fp_product_arbiter_rr.sv
// ---------------------------------------------------------------------------
// fp_rr_arbiter
// Two-way round-robin grant with a single priority pointer.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (pointer -> 0)
//   en              grants allowed this cycle
//   valid0, valid1  request lines
//   grant0, grant1  one-hot (or zero) combinational grant
// On a simultaneous request the pointed requester wins; after any grant
// the pointer moves to the other requester.
// ---------------------------------------------------------------------------
module fp_rr_arbiter
   import fp_product_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic valid0,
   input  logic valid1,
   output logic grant0,
   output logic grant1
);

   logic ptr;

   assign grant0 = en & valid0 & (~valid1 | ~ptr);
   assign grant1 = en & valid1 & (~valid0 |  ptr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (grant0) begin
         ptr <= 1'b1;
      end else if (grant1) begin
         ptr <= 1'b0;
      end
   end

endmodule

// File: rtl/fp_product_arbiter.sv
// ---------------------------------------------------------------------------
// fp_product_arbiter
// Shares one floating-point product unit between two requesters, with
// exactly one transaction in flight (IDLE -> BUSY -> RESP).
// Ports:
//   i_clock, i_reset_n             clock, asynchronous active-low reset
//   i_reqN_valid, i_reqN_dataA/B   requester N operand pair
//   o_reqN_ready                   grant/accept pulse (IDLE only)
//   o_mul_dataA/B                  operand register, drives the product unit
//   i_mul_data                     product unit result
//   o_rsp_valid/data/id/exc        response, held until i_rsp_ready
//   i_rsp_ready                    response consumer ready
// Optional feature: define FP_PRODUCT_ARB_EXC_EN to classify zero/inf
// operands and override the product; otherwise the captured product is
// returned unchanged and o_rsp_exc is tied to 00.
// MUL_LAT is the number of BUSY cycles (1..15).
// ---------------------------------------------------------------------------
module fp_product_arbiter
   import fp_product_arbiter_pkg::*;
#(
   parameter int NB_SIGN = NB_SIGN_DEF,
   parameter int NB_EXPO = NB_EXPO_DEF,
   parameter int NB_MANT = NB_MANT_DEF,
   parameter int NB      = NB_SIGN + NB_EXPO + NB_MANT,
   parameter int MUL_LAT = 2
) (
   input  logic          i_clock,
   input  logic          i_reset_n,
   input  logic          i_req0_valid,
   input  logic          i_req1_valid,
   input  logic [NB-1:0] i_req0_dataA,
   input  logic [NB-1:0] i_req0_dataB,
   input  logic [NB-1:0] i_req1_dataA,
   input  logic [NB-1:0] i_req1_dataB,
   output logic          o_req0_ready,
   output logic          o_req1_ready,
   output logic [NB-1:0] o_mul_dataA,
   output logic [NB-1:0] o_mul_dataB,
   input  logic [NB-1:0] i_mul_data,
   output logic          o_rsp_valid,
   output logic [NB-1:0] o_rsp_data,
   output logic          o_rsp_id,
   output logic [1:0]    o_rsp_exc,
   input  logic          i_rsp_ready
);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] BUSY = ST_BUSY;
   localparam logic [1:0] RESP = ST_RESP;

   localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

   logic [1:0]    state;
   logic [3:0]    busy_cnt;
   logic          arb_en;
   logic          gnt0;
   logic          gnt1;
   logic          cap_en;

   logic [NB-1:0] opa_p1;
   logic [NB-1:0] opb_p1;
   logic          id_p1;

   logic [NB-1:0] cap_data;
   logic [NB-1:0] rsp_data_p2;
   logic          rsp_id_p2;
   logic          vld_p2;

   // Reset is folded into the enable so readies are low while reset is
   // asserted even if a requester is already presenting valid.
   assign arb_en = (state == IDLE) && i_reset_n;

   fp_rr_arbiter u_rr (
      .clk    (i_clock),
      .rst_n  (i_reset_n),
      .en     (arb_en),
      .valid0 (i_req0_valid),
      .valid1 (i_req1_valid),
      .grant0 (gnt0),
      .grant1 (gnt1)
   );

   assign o_req0_ready = gnt0;
   assign o_req1_ready = gnt1;

   // Last BUSY cycle: product unit output is sampled here.
   assign cap_en = (state == BUSY) && (busy_cnt == 4'd0);

`ifdef FP_PRODUCT_ARB_EXC_EN
   logic [1:0] cap_exc;
   logic [1:0] rsp_exc_p2;

   // Returns {exc, data}. A zero-exponent operand wins over an
   // all-ones-exponent operand.
   function automatic logic [NB+1:0] classify(input logic [NB-1:0] a,
                                               input logic [NB-1:0] b,
                                               input logic [NB-1:0] mul);
      logic sgn;
      logic zero_op;
      logic inf_op;
      sgn     = a[NB-1] ^ b[NB-1];
      zero_op = (a[NB-2 -: NB_EXPO] == '0) || (b[NB-2 -: NB_EXPO] == '0);
      inf_op  = (a[NB-2 -: NB_EXPO] == '1) || (b[NB-2 -: NB_EXPO] == '1);
      if (zero_op) begin
         classify = {EXC_ZERO, sgn, {NB_EXPO{1'b0}}, {NB_MANT{1'b0}}};
      end else if (inf_op) begin
         classify = {EXC_INF, sgn, {NB_EXPO{1'b1}}, {NB_MANT{1'b0}}};
      end else begin
         classify = {EXC_NORMAL, mul};
      end
   endfunction

   assign {cap_exc, cap_data} = classify(opa_p1, opb_p1, i_mul_data);

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rsp_exc_p2 <= EXC_NORMAL;
      end else if (cap_en) begin
         rsp_exc_p2 <= cap_exc;
      end
   end

   assign o_rsp_exc = rsp_exc_p2;
`else
   assign cap_data  = i_mul_data;
   assign o_rsp_exc = EXC_NORMAL;
`endif

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state       <= IDLE;
         busy_cnt    <= 4'd0;
         opa_p1      <= '0;
         opb_p1      <= '0;
         id_p1       <= 1'b0;
         rsp_data_p2 <= '0;
         rsp_id_p2   <= 1'b0;
      end else begin
         case (state)
            // p0 -> p1: accept the granted operand pair
            IDLE: begin
               if (gnt0 || gnt1) begin
                  opa_p1   <= gnt1 ? i_req1_dataA : i_req0_dataA;
                  opb_p1   <= gnt1 ? i_req1_dataB : i_req0_dataB;
                  id_p1    <= gnt1;
                  busy_cnt <= CNT_LOAD;
                  state    <= BUSY;
               end
            end
            // p1 -> p2: wait out the product unit, then capture
            BUSY: begin
               if (busy_cnt == 4'd0) begin
                  rsp_data_p2 <= cap_data;
                  rsp_id_p2   <= id_p1;
                  state       <= RESP;
               end else begin
                  busy_cnt <= busy_cnt - 4'd1;
               end
            end
            RESP: begin
               if (i_rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign vld_p2 = (state == RESP);

   assign o_mul_dataA = opa_p1;
   assign o_mul_dataB = opb_p1;
   assign o_rsp_valid = vld_p2;
   assign o_rsp_data  = rsp_data_p2;
   assign o_rsp_id    = rsp_id_p2;

endmodule

// File: doc/fp_product_arbiter.md
FP_PRODUCT_ARBITER -- requirements
Module: fp_product_arbiter

Interface
REQ-001 Parameters SHALL be NB_SIGN, default 1, sign width; NB_EXPO, default 4, exponent width; NB_MANT, default 8, mantissa width; NB, default NB_SIGN+NB_EXPO+NB_MANT, word width; MUL_LAT, default 2, cycles from operand issue to result capture (legal range 1..15).
REQ-002 One clock and one reset SHALL be used; reset is asynchronous and active-low.
REQ-003 Ports SHALL be:
- i_clock  in  1  clock, rising edge.
- i_reset_n  in  1  async active-low reset.
- i_req0_valid / i_req1_valid  in  1  requester operand pair valid.
- i_req0_dataA, i_req0_dataB, i_req1_dataA, i_req1_dataB  in  NB  operands, {sign, expo, mant}.
- o_req0_ready / o_req1_ready  out  1  grant/accept pulse.
- o_mul_dataA, o_mul_dataB  out  NB  operands driven to the shared product unit.
- i_mul_data  in  NB  product unit result.
- o_rsp_valid  out  1  response valid.
- o_rsp_data  out  NB  product result.
- o_rsp_id  out  1  requester index of the response.
- o_rsp_exc  out  2  exception class: 00 normal, 01 zero, 10 inf.
- i_rsp_ready  in  1  response consumer ready.

Function
REQ-004 FSM states SHALL be IDLE, BUSY, RESP; exactly one transaction in flight.
REQ-005 In IDLE with any valid, o_reqN_ready SHALL assert combinationally for the granted requester only; handshake completes that cycle; operands latched into the operand register; next state BUSY.
REQ-006 Ready SHALL be 0 in BUSY and RESP; a requester may drop valid before ready without effect.
REQ-007 Arbitration SHALL be round-robin: one priority bit; on simultaneous valids the pointed requester wins; after any grant, pointer = other requester.
REQ-008 o_mul_dataA/B SHALL continuously reflect the operand register (held after the transaction).
REQ-009 A BUSY down-counter SHALL load MUL_LAT-1 on entry; BUSY lasts exactly MUL_LAT cycles; on its last cycle i_mul_data is captured into the response register and state moves to RESP.
REQ-010 Grant at cycle T SHALL yield o_rsp_valid=1 at cycle T+1+MUL_LAT.
REQ-011 In RESP, o_rsp_valid/data/id/exc SHALL be stable while i_rsp_ready=0; on i_rsp_ready=1 next state IDLE, o_rsp_valid=0 next cycle.
REQ-012 Back-to-back: a new grant SHALL occur no earlier than the cycle after the response handshake (minimum period MUL_LAT+2 cycles).
REQ-013 o_rsp_id SHALL equal the index granted for that transaction.

Reset
REQ-014 On i_reset_n=0, state=IDLE, pointer=0, counter=0, operand and response registers=0, o_rsp_valid=0, readies=0; applied immediately.
REQ-015 Reset mid-transaction SHALL discard it with no response produced; first grant after release follows pointer=0.

Configuration
REQ-016 Macro FP_PRODUCT_ARB_EXC_EN SHALL gate exception handling.
REQ-017 With it defined: any operand with expo=0 SHALL force o_rsp_data={sA^sB, 0, 0}, exc=01; else any operand with expo all-ones SHALL force {sA^sB, all-ones, 0}, exc=10; zero takes precedence over inf; otherwise data=i_mul_data, exc=00.
REQ-018 Without it: o_rsp_data = captured i_mul_data, o_rsp_exc tied 00; no classification logic.

Structure
REQ-019 A shared package SHALL hold NB_SIGN/NB_EXPO/NB_MANT defaults, the FSM state enum, and the exc code constants.
REQ-020 Arbitration SHALL be one sub-module fp_rr_arbiter (2-way round-robin grant + pointer update); the rest stays in the top.

Verification (bench drives i_mul_data from a reference product model, MUL_LAT=2)
REQ-021 Single req0, A=0_0111_11000000, B=0_0101_10100000 at T -> ready0 at T, o_mul_dataA/B match at T+1, rsp_valid at T+3, id=0, data = model result.
REQ-022 Both valid at T after reset -> req0 granted at T; req1 held valid granted after response handshake; next simultaneous round grants req0 again only after req1.
REQ-023 Hold i_rsp_ready=0 for 5 cycles in RESP -> rsp fields unchanged, both readies 0 throughout.
REQ-024 Assert i_reset_n=0 during BUSY -> no rsp_valid; all outputs 0; next grant honours pointer=0.
REQ-025 With FP_PRODUCT_ARB_EXC_EN: A=0_0000_00000000, B=0_0101_10000000 -> data 0_0000_00000000, exc 01; A=0_1111_00000000, B=1_0101_10100000 -> data 1_1111_00000000, exc 10; without macro exc=00 and data = model output.
REQ-026 Sweep MUL_LAT=1 and 15 -> response latency T+1+MUL_LAT exactly.
